// File: rtl/task_slave_port.sv
// -----------------------------------------------------------------------------
// task_slave_port
// Task-side endpoint of the task_in/task_out link (the task manager is master).
// Requests test-vector bytes from the manager, buffers them in a first-word
// fall-through FIFO and streams them to the compute core; buffers the core's
// answer words and hands them back to the manager with a last flag.
//
// Ports
//   i_clk, i_rst_n, i_clear        clock, async active-low reset, sync flush
//   task_data_valid/_data/_last    byte stream from manager
//   task_data_request              registered "send more bytes" to manager
//   task_answer_ready/_data/_last  head of the answer FIFO toward manager
//   task_manager_ready             manager consumes head word this cycle
//   core_byte_valid/_byte/_last    byte stream to core, core_byte_ready back
//   core_ans_valid/_data/_last     answer words from core, core_ans_ready back
//   o_state, o_done                FSM state encoding, high in DONE
//   o_rx_cnt, o_tx_cnt, o_overflow statistics (TASK_PORT_STATS_EN), else 0
//
// Configuration macro: TASK_PORT_STATS_EN enables the statistics outputs.
// -----------------------------------------------------------------------------
module task_slave_port #(
    parameter int DIN_WIDTH   = 8,
    parameter int DOUT_WIDTH  = 32,
    parameter int IN_DEPTH    = 16,
    parameter int OUT_DEPTH   = 8,
    parameter int TV_IN_BYTES = 64,
    parameter int REQ_SLACK   = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clear,
    input  logic                  task_data_valid,
    input  logic [DIN_WIDTH-1:0]  task_data,
    input  logic                  task_data_last,
    output logic                  task_data_request,
    output logic                  task_answer_ready,
    output logic [DOUT_WIDTH-1:0] task_answer_data,
    output logic                  task_answer_data_last,
    input  logic                  task_manager_ready,
    output logic                  core_byte_valid,
    output logic                  core_byte_last,
    output logic [DIN_WIDTH-1:0]  core_byte,
    input  logic                  core_byte_ready,
    input  logic                  core_ans_valid,
    input  logic                  core_ans_last,
    input  logic [DOUT_WIDTH-1:0] core_ans_data,
    output logic                  core_ans_ready,
    output logic [2:0]            o_state,
    output logic                  o_done,
    output logic [11:0]           o_rx_cnt,
    output logic [11:0]           o_tx_cnt,
    output logic                  o_overflow
);

    localparam int IAW = $clog2(IN_DEPTH);
    localparam int OAW = $clog2(OUT_DEPTH);
    localparam int REQ_LIMIT = IN_DEPTH - REQ_SLACK;     // free_slots > REQ_SLACK <=> count < this
    localparam logic [IAW:0] REQ_LIMIT_W = REQ_LIMIT[IAW:0];
    localparam logic [11:0]  TV_W        = TV_IN_BYTES[11:0];

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RECEIVE = 3'd1,
        S_PROCESS = 3'd2,
        S_ANSWER  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    state_t state, state_next;

    // Input byte FIFO: {last, byte}; pointers carry one extra wrap bit.
    logic [DIN_WIDTH:0]  in_mem [IN_DEPTH];
    logic [IAW:0]        in_wr, in_rd, in_count;
    logic                in_empty, in_full, in_push, in_pop, rx_offer;
    logic [DIN_WIDTH:0]  in_head;

    // Output answer FIFO: {last, word}.
    logic [DOUT_WIDTH:0] out_mem [OUT_DEPTH];
    logic [OAW:0]        out_wr, out_rd;
    logic                out_empty, out_full, out_push, out_pop;
    logic [DOUT_WIDTH:0] out_head;

    logic [11:0] rx_cnt, rx_cnt_inc, req_cnt, req_cnt_next;
    logic        req_next;

    assign in_count = in_wr - in_rd;
    assign in_empty = (in_wr == in_rd);
    assign in_full  = (in_wr[IAW] != in_rd[IAW]) && (in_wr[IAW-1:0] == in_rd[IAW-1:0]);
    assign in_head  = in_mem[in_rd[IAW-1:0]];

    assign out_empty = (out_wr == out_rd);
    assign out_full  = (out_wr[OAW] != out_rd[OAW]) && (out_wr[OAW-1:0] == out_rd[OAW-1:0]);
    assign out_head  = out_mem[out_rd[OAW-1:0]];

    // Core byte side (FWFT). Outputs are masked while empty so stale or
    // never-written memory contents never reach the ports.
    assign core_byte_valid = !in_empty;
    assign core_byte       = in_empty ? '0 : in_head[DIN_WIDTH-1:0];
    assign core_byte_last  = !in_empty && in_head[DIN_WIDTH];
    assign in_pop          = core_byte_valid && core_byte_ready;

    // A full FIFO still accepts a byte in the cycle it is also being popped.
    assign rx_offer   = (state == S_RECEIVE) && task_data_valid;
    assign in_push    = rx_offer && (!in_full || in_pop);
    assign rx_cnt_inc = sat_inc(rx_cnt);

    // Answer side.
    assign core_ans_ready        = !out_full && ((state == S_RECEIVE) || (state == S_PROCESS));
    assign out_push              = core_ans_valid && core_ans_ready;
    assign task_answer_ready     = (state == S_ANSWER) && !out_empty;
    assign task_answer_data      = out_empty ? '0 : out_head[DOUT_WIDTH-1:0];
    assign task_answer_data_last = !out_empty && out_head[DOUT_WIDTH];
    assign out_pop               = task_answer_ready && task_manager_ready;

    // The request is registered, so judge the request budget on the count as
    // it will be after this cycle; that keeps the total at TV_IN_BYTES.
    assign req_cnt_next = task_data_request ? sat_inc(req_cnt) : req_cnt;
    assign req_next     = (state == S_RECEIVE) && (in_count < REQ_LIMIT_W) && (req_cnt_next < TV_W);

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:    state_next = S_RECEIVE;
            S_RECEIVE: if (in_push && (task_data_last || rx_cnt_inc >= TV_W)) state_next = S_PROCESS;
            S_PROCESS: if (out_push && core_ans_last) state_next = S_ANSWER;
            S_ANSWER:  if (out_pop && out_head[DOUT_WIDTH]) state_next = S_DONE;
            S_DONE:    state_next = S_DONE;
            default:   state_next = S_IDLE;
        endcase
        if (i_clear) state_next = S_IDLE;     // clear overrides every other event
    end

    // NOTE: FIFO storage has no reset; the pointers define validity and the
    // empty masks above keep unwritten entries off the outputs.
    always_ff @(posedge i_clk) begin
        if (in_push)  in_mem[in_wr[IAW-1:0]]   <= {task_data_last, task_data};
        if (out_push) out_mem[out_wr[OAW-1:0]] <= {core_ans_last, core_ans_data};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state             <= S_IDLE;
            in_wr             <= '0;
            in_rd             <= '0;
            out_wr            <= '0;
            out_rd            <= '0;
            rx_cnt            <= '0;
            req_cnt           <= '0;
            task_data_request <= 1'b0;
        end else if (i_clear) begin
            state             <= S_IDLE;
            in_wr             <= '0;
            in_rd             <= '0;
            out_wr            <= '0;
            out_rd            <= '0;
            rx_cnt            <= '0;
            req_cnt           <= '0;
            task_data_request <= 1'b0;
        end else begin
            state             <= state_next;
            task_data_request <= req_next;
            req_cnt           <= req_cnt_next;
            if (in_push) begin
                in_wr  <= in_wr + 1'b1;
                rx_cnt <= rx_cnt_inc;
            end
            if (in_pop)   in_rd  <= in_rd + 1'b1;
            if (out_push) out_wr <= out_wr + 1'b1;
            if (out_pop)  out_rd <= out_rd + 1'b1;
        end
    end

    assign o_state = state;
    assign o_done  = (state == S_DONE);

`ifdef TASK_PORT_STATS_EN
    logic [11:0] tx_cnt;
    logic        overflow;
    logic        byte_drop;

    assign byte_drop = rx_offer && !in_push;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_cnt   <= '0;
            overflow <= 1'b0;
        end else if (i_clear) begin
            tx_cnt   <= '0;
            overflow <= 1'b0;
        end else begin
            if (out_pop)   tx_cnt   <= sat_inc(tx_cnt);
            if (byte_drop) overflow <= 1'b1;
        end
    end

    assign o_rx_cnt   = rx_cnt;
    assign o_tx_cnt   = tx_cnt;
    assign o_overflow = overflow;
`else
    assign o_rx_cnt   = '0;
    assign o_tx_cnt   = '0;
    assign o_overflow = 1'b0;
`endif

endmodule
